// File: rtl/pulse_cmd_queue.sv
// Command FIFO feeding a downstream pulser through a valid/ready/ack handshake.
// Each acknowledged command is popped and counted; the sink must cycle ready low->high before the next offer.
module pulse_cmd_queue #(
    parameter int DEPTH = 4,
    parameter int CW    = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [CW-1:0]              push_count,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       overflow,
    output logic                       valid,
    output logic [CW-1:0]              count,
    input  logic                       ready,
    input  logic                       ack,
    output logic [15:0]                issued
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    typedef enum logic [1:0] {IDLE, OFFER, WAIT_BUSY, WAIT_RDY} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] mem [DEPTH];
    logic [AW-1:0] head, tail;
    logic          push_acc, push_rej, pop;

    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);

    // A full FIFO rejects pushes even when a pop lands in the same cycle.
    assign push_acc = push && !full && (push_count != '0);
    assign push_rej = push &&  full && (push_count != '0);
    assign pop      = (state == OFFER) && ack;

    assign valid = (state == OFFER);
    assign count = valid ? mem[head] : '0;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (!empty && ready && !ack) state_nx = OFFER;
            OFFER:     if (ack)                     state_nx = WAIT_BUSY;
            WAIT_BUSY: if (!ready)                  state_nx = WAIT_RDY;
            WAIT_RDY:  if (ready && !ack)           state_nx = IDLE;
            default:                                state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            head     <= '0;
            tail     <= '0;
            level    <= '0;
            overflow <= 1'b0;
            issued   <= '0;
        end else begin
            state <= state_nx;
            // DEPTH is a power of two, so pointer wrap is the natural AW-bit rollover.
            if (push_acc) tail <= tail + 1'b1;
            if (pop) begin
                head   <= head + 1'b1;
                issued <= issued + 1'b1;
            end
            if (push_rej) overflow <= 1'b1;
            case ({push_acc, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Storage is data only and keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (push_acc) mem[tail] <= push_count;
    end

endmodule

// File: tb/tb_pulse_cmd_queue.sv
// Directed bench for pulse_cmd_queue: a vector table for the FIFO/handshake flow,
// plus hand sequences for the ready-gap and reset-mid-offer cases.
module tb_pulse_cmd_queue;

    localparam int DEPTH = 4;
    localparam int CW    = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          push = 1'b0;
    logic [CW-1:0] push_count = '0;
    logic          full, empty, overflow, valid;
    logic [2:0]    level;
    logic [CW-1:0] count;
    logic          ready = 1'b0;
    logic          ack = 1'b0;
    logic [15:0]   issued;

    int n_cmp  = 0;
    int n_fail = 0;

    pulse_cmd_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .rst(rst), .push(push), .push_count(push_count),
        .full(full), .empty(empty), .level(level), .overflow(overflow),
        .valid(valid), .count(count), .ready(ready), .ack(ack), .issued(issued)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        push;
        logic [31:0] pc;
        logic        ready;
        logic        ack;
        logic        valid;
        logic [31:0] count;
        logic [2:0]  level;
        logic        full;
        logic        empty;
        logic        ovf;
        logic [15:0] issued;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic p, logic [31:0] pc, logic r, logic a,
                                logic v, logic [31:0] c, logic [2:0] l,
                                logic f, logic e, logic o, logic [15:0] i);
        vec_t t;
        t.push = p; t.pc = pc; t.ready = r; t.ack = a;
        t.valid = v; t.count = c; t.level = l; t.full = f; t.empty = e;
        t.ovf = o; t.issued = i;
        return t;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input vec_t e);
        n_cmp++;
        if (valid !== e.valid || count !== e.count || level !== e.level || full !== e.full ||
            empty !== e.empty || overflow !== e.ovf || issued !== e.issued) begin
            n_fail++;
            $display("FAIL %s: got v=%0b c=%0d l=%0d f=%0b e=%0b o=%0b i=%0d expected v=%0b c=%0d l=%0d f=%0b e=%0b o=%0b i=%0d",
                     name, valid, count, level, full, empty, overflow, issued,
                     e.valid, e.count, e.level, e.full, e.empty, e.ovf, e.issued);
        end
    endtask

    task automatic do_reset();
        vec_t r;
        push = 1'b0; push_count = '0; ack = 1'b0; ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        r = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        check_all("reset_state", r);
        rst = 1'b0;
    endtask

    initial begin
        int n;
        logic bad;

        //        push pc  rdy ack | vld cnt lvl full empty ovf iss
        vecs.push_back(mk(1, 5, 1, 0,   0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0,   1, 5, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1,   0, 0, 0, 0, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0,   0, 0, 0, 0, 1, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0,   0, 0, 0, 0, 1, 0, 1));
        vecs.push_back(mk(1, 0, 1, 0,   0, 0, 0, 0, 1, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0,   0, 0, 0, 0, 1, 0, 1));
        vecs.push_back(mk(1, 1, 0, 0,   0, 0, 1, 0, 0, 0, 1));
        vecs.push_back(mk(1, 2, 0, 0,   0, 0, 2, 0, 0, 0, 1));
        vecs.push_back(mk(1, 3, 0, 0,   0, 0, 3, 0, 0, 0, 1));
        vecs.push_back(mk(1, 4, 0, 0,   0, 0, 4, 1, 0, 0, 1));
        vecs.push_back(mk(1, 5, 0, 0,   0, 0, 4, 1, 0, 1, 1));
        vecs.push_back(mk(0, 0, 1, 0,   1, 1, 4, 1, 0, 1, 1));
        vecs.push_back(mk(1, 9, 1, 1,   0, 0, 3, 0, 0, 1, 2));
        vecs.push_back(mk(0, 0, 0, 0,   0, 0, 3, 0, 0, 1, 2));
        vecs.push_back(mk(0, 0, 1, 0,   0, 0, 3, 0, 0, 1, 2));
        vecs.push_back(mk(0, 0, 1, 0,   1, 2, 3, 0, 0, 1, 2));
        vecs.push_back(mk(0, 0, 1, 1,   0, 0, 2, 0, 0, 1, 3));
        vecs.push_back(mk(0, 0, 0, 1,   0, 0, 2, 0, 0, 1, 3));
        vecs.push_back(mk(0, 0, 1, 0,   0, 0, 2, 0, 0, 1, 3));
        vecs.push_back(mk(0, 0, 1, 1,   0, 0, 2, 0, 0, 1, 3));
        vecs.push_back(mk(0, 0, 1, 0,   1, 3, 2, 0, 0, 1, 3));
        vecs.push_back(mk(1, 8, 1, 0,   1, 3, 3, 0, 0, 1, 3));
        vecs.push_back(mk(0, 0, 1, 1,   0, 0, 2, 0, 0, 1, 4));
        vecs.push_back(mk(0, 0, 0, 0,   0, 0, 2, 0, 0, 1, 4));
        vecs.push_back(mk(0, 0, 1, 0,   0, 0, 2, 0, 0, 1, 4));
        vecs.push_back(mk(0, 0, 1, 0,   1, 4, 2, 0, 0, 1, 4));
        vecs.push_back(mk(0, 0, 1, 1,   0, 0, 1, 0, 0, 1, 5));
        vecs.push_back(mk(0, 0, 0, 0,   0, 0, 1, 0, 0, 1, 5));
        vecs.push_back(mk(0, 0, 1, 0,   0, 0, 1, 0, 0, 1, 5));
        vecs.push_back(mk(0, 0, 1, 0,   1, 8, 1, 0, 0, 1, 5));
        vecs.push_back(mk(0, 0, 1, 1,   0, 0, 0, 0, 1, 1, 6));

        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            push = vecs[i].push; push_count = vecs[i].pc;
            ready = vecs[i].ready; ack = vecs[i].ack;
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i]);
        end

        // Two commands, sink drops ready for 10 cycles after each ack.
        do_reset();
        ready = 1'b1;
        push = 1'b1; push_count = 5;
        @(posedge clk); #1;
        push_count = 6;
        @(posedge clk); #1;
        push = 1'b0; push_count = 0;
        n = 0;
        while (!valid && n < 10) begin @(posedge clk); #1; n++; end
        check("gap_first_valid", {63'd0, valid}, 64'd1);
        check("gap_first_count", {32'd0, count}, 64'd5);
        ack = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0; ready = 1'b0;
        check("gap_valid_after_ack", {63'd0, valid}, 64'd0);
        bad = 1'b0;
        repeat (10) begin @(posedge clk); #1; if (valid) bad = 1'b1; end
        check("gap_no_offer_ready_low", {63'd0, bad}, 64'd0);
        ready = 1'b1;
        n = 0;
        while (!valid && n < 10) begin @(posedge clk); #1; n++; end
        check("gap_cycles_to_second", 64'(n), 64'd2);
        check("gap_second_count", {32'd0, count}, 64'd6);
        ack = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0; ready = 1'b0;
        repeat (10) @(posedge clk);
        #1; ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("gap_issued", {48'd0, issued}, 64'd2);
        check("gap_idle_empty", {62'd0, valid, empty}, 64'd1);

        // Reset mid-offer drops the command without counting it.
        do_reset();
        ready = 1'b1;
        push = 1'b1; push_count = 7;
        @(posedge clk); #1;
        push = 1'b0; push_count = 0;
        n = 0;
        while (!valid && n < 10) begin @(posedge clk); #1; n++; end
        check("rst_offer_count", {31'd0, valid, count}, {31'd0, 1'b1, 32'd7});
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_outputs", {59'd0, valid, level, empty}, {59'd0, 1'b0, 3'd0, 1'b1});
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("rst_issued_after", {48'd0, issued}, 64'd0);
        check("rst_no_offer", {63'd0, valid}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
